// File: rtl/axi_wr_slave_mem.sv
// axi_wr_slave_mem
// AXI4 write-channel slave that backs a small byte-addressed RAM.
// One burst is in flight at a time: AW capture -> W beats -> B response.
// Strobed bytes of each beat are committed to the word addressed by the
// running byte address. A registered debug port lets the RAM image be
// read back one word per cycle.

module axi_wr_slave_mem #(
    parameter int AWID_WIDTH   = 4,
    parameter int AWADDR_WIDTH = 10,
    parameter int WDATA_WIDTH  = 64,
    parameter int WSTRB_WIDTH  = WDATA_WIDTH / 8,
    parameter int LANE_BITS    = 3
) (
    input  logic                              clk,
    input  logic                              rst_n,
    // write address channel
    input  logic [AWID_WIDTH-1:0]             AWID,
    input  logic [AWADDR_WIDTH-1:0]           AWADDR,
    input  logic [7:0]                        AWLEN,
    input  logic [2:0]                        AWSIZE,
    input  logic [1:0]                        AWBURST,
    input  logic [3:0]                        AWREGION,
    input  logic                              AWVALID,
    output logic                              AWREADY,
    // write data channel
    input  logic [WDATA_WIDTH-1:0]            WDATA,
    input  logic [WSTRB_WIDTH-1:0]            WSTRB,
    input  logic                              WLAST,
    input  logic                              WVALID,
    output logic                              WREADY,
    // write response channel
    output logic [AWID_WIDTH-1:0]             BID,
    output logic [1:0]                        BRESP,
    output logic                              BVALID,
    input  logic                              BREADY,
    // debug read port
    input  logic [AWADDR_WIDTH-LANE_BITS-1:0] dbg_addr,
    output logic [WDATA_WIDTH-1:0]            dbg_rdata
);

    localparam int IDX_W = AWADDR_WIDTH - LANE_BITS;
    localparam int DEPTH = 1 << IDX_W;

    // FSM encoding
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_DATA = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [AWADDR_WIDTH-1:0] ADDR_ONE = {{(AWADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [8:0]              CNT_MAX  = 9'd256;

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------

    // A burst is unusable if its type is reserved/WRAP or a beat is wider
    // than the data bus.
    function automatic logic burst_illegal(input logic [1:0] burst,
                                           input logic [2:0] size);
        burst_illegal = burst[1] || (size > 3'(LANE_BITS));
    endfunction

    // Address of the following beat; INCR wraps naturally at the top of
    // the address space, FIXED stays put.
    function automatic logic [AWADDR_WIDTH-1:0] next_beat_addr(
        input logic [AWADDR_WIDTH-1:0] addr,
        input logic [1:0]              burst,
        input logic [2:0]              size);
        if (burst == BURST_INCR) begin
            next_beat_addr = addr + (ADDR_ONE << size);
        end else begin
            next_beat_addr = addr;
        end
    endfunction

    // Beat counter that sticks at 256 so a runaway master cannot wrap it
    // back into the legal range.
    function automatic logic [8:0] sat_inc(input logic [8:0] cnt);
        if (cnt == CNT_MAX) begin
            sat_inc = cnt;
        end else begin
            sat_inc = cnt + 9'd1;
        end
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]              state_r;
    logic [AWID_WIDTH-1:0]   id_r;
    logic [AWADDR_WIDTH-1:0] addr_r;
    logic [7:0]              len_r;
    logic [2:0]              size_r;
    logic [1:0]              burst_r;
    logic [8:0]              beat_cnt_r;
    logic                    err_r;
    logic                    awready_r;
    logic                    wready_r;
    logic                    bvalid_r;
    logic [AWID_WIDTH-1:0]   bid_r;
    logic [1:0]              bresp_r;
    logic [WDATA_WIDTH-1:0]  dbg_rdata_r;

    logic [WDATA_WIDTH-1:0]  mem [DEPTH];

    // ------------------------------------------------------------------
    // Per-beat decode
    // ------------------------------------------------------------------
    logic             aw_fire_s;
    logic             w_fire_s;
    logic             b_fire_s;
    logic             beat_in_range_s;
    logic [8:0]       beat_cnt_next_s;
    logic             last_err_s;
    logic             resp_err_s;
    logic             mem_we_s;
    logic [IDX_W-1:0] mem_idx_s;

    // Region hint carries no meaning for a flat memory.
    logic unused_s;
    assign unused_s = ^AWREGION;

    // Handshakes, beat legality and the RAM write request for this cycle.
    always_comb begin
        aw_fire_s       = 1'b0;
        w_fire_s        = 1'b0;
        b_fire_s        = 1'b0;
        beat_in_range_s = 1'b0;
        beat_cnt_next_s = beat_cnt_r;
        last_err_s      = 1'b0;
        resp_err_s      = err_r;
        mem_we_s        = 1'b0;
        mem_idx_s       = addr_r[AWADDR_WIDTH-1:LANE_BITS];

        if (state_r == ST_IDLE) begin
            aw_fire_s = AWVALID && awready_r;
        end else begin
            aw_fire_s = 1'b0;
        end

        w_fire_s        = WVALID && wready_r;
        b_fire_s        = bvalid_r && BREADY;
        beat_in_range_s = (beat_cnt_r <= {1'b0, len_r});
        beat_cnt_next_s = sat_inc(beat_cnt_r);

        // Burst closed with a beat count different from AWLEN+1.
        if (WLAST && (beat_cnt_next_s != ({1'b0, len_r} + 9'd1))) begin
            last_err_s = 1'b1;
        end else begin
            last_err_s = 1'b0;
        end

        resp_err_s = err_r || !beat_in_range_s || last_err_s;

        // Beats past the announced length, or of an illegal burst, are
        // accepted on the bus but dropped.
        if (w_fire_s && !err_r && beat_in_range_s) begin
            mem_we_s = 1'b1;
        end else begin
            mem_we_s = 1'b0;
        end
    end

    // Transaction FSM, captured AW fields and the registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            id_r       <= {AWID_WIDTH{1'b0}};
            addr_r     <= {AWADDR_WIDTH{1'b0}};
            len_r      <= 8'd0;
            size_r     <= 3'd0;
            burst_r    <= 2'b00;
            beat_cnt_r <= 9'd0;
            err_r      <= 1'b0;
            awready_r  <= 1'b1;
            wready_r   <= 1'b0;
            bvalid_r   <= 1'b0;
            bid_r      <= {AWID_WIDTH{1'b0}};
            bresp_r    <= RESP_OKAY;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (aw_fire_s) begin
                        id_r       <= AWID;
                        addr_r     <= AWADDR;
                        len_r      <= AWLEN;
                        size_r     <= AWSIZE;
                        burst_r    <= AWBURST;
                        beat_cnt_r <= 9'd0;
                        err_r      <= burst_illegal(AWBURST, AWSIZE);
                        awready_r  <= 1'b0;
                        wready_r   <= 1'b1;
                        state_r    <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (w_fire_s) begin
                        addr_r     <= next_beat_addr(addr_r, burst_r, size_r);
                        beat_cnt_r <= beat_cnt_next_s;
                        if (!beat_in_range_s) begin
                            err_r <= 1'b1;
                        end
                        if (WLAST) begin
                            err_r    <= resp_err_s;
                            wready_r <= 1'b0;
                            bvalid_r <= 1'b1;
                            bid_r    <= id_r;
                            bresp_r  <= resp_err_s ? RESP_SLVERR : RESP_OKAY;
                            state_r  <= ST_RESP;
                        end
                    end
                end
                ST_RESP: begin
                    // BID/BRESP are only loaded on entry, so they hold
                    // steady for as long as the master stalls BREADY.
                    if (b_fire_s) begin
                        bvalid_r  <= 1'b0;
                        awready_r <= 1'b1;
                        state_r   <= ST_IDLE;
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    awready_r <= 1'b1;
                    wready_r  <= 1'b0;
                    bvalid_r  <= 1'b0;
                end
            endcase
        end
    end

    // Byte-lane writes into the RAM; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            for (int i = 0; i < WSTRB_WIDTH; i++) begin
                if (WSTRB[i]) begin
                    mem[mem_idx_s][i*8 +: 8] <= WDATA[i*8 +: 8];
                end
            end
        end
    end

    // Registered debug read; a colliding write is seen on the next read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dbg_rdata_r <= {WDATA_WIDTH{1'b0}};
        end else begin
            dbg_rdata_r <= mem[dbg_addr];
        end
    end

    assign AWREADY   = awready_r;
    assign WREADY    = wready_r;
    assign BVALID    = bvalid_r;
    assign BID       = bid_r;
    assign BRESP     = bresp_r;
    assign dbg_rdata = dbg_rdata_r;

endmodule

// File: doc/axi_wr_slave_mem.md
Name: axi_wr_slave_mem

Overview:
- AXI4 write-channel slave memory that sits directly downstream of the TPU top-level AW/W/B write master.
- Accepts one write burst at a time and commits strobed bytes into an internal byte-addressed RAM.
- Returns a write response carrying the captured AWID.
- Provides a registered debug read port so the DRAM image produced by the TPU can be checked.

Parameters:
- AWID_WIDTH, 4, width of AWID/BID.
- AWADDR_WIDTH, 10, byte address width; memory size is 2^AWADDR_WIDTH bytes.
- WDATA_WIDTH, 64, data beat width; must be 8*2^k.
- WSTRB_WIDTH, WDATA_WIDTH/8, byte-strobe width.
- LANE_BITS, 3, log2(WSTRB_WIDTH).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- AWID  in  AWID_WIDTH  write transaction ID.
- AWADDR  in  AWADDR_WIDTH  burst start byte address.
- AWLEN  in  8  beats minus 1.
- AWSIZE  in  3  log2 bytes per beat.
- AWBURST  in  2  00 FIXED, 01 INCR, 10/11 unsupported.
- AWREGION  in  4  ignored.
- AWVALID  in  1  address valid.
- AWREADY  out  1  address ready.
- WDATA  in  WDATA_WIDTH  beat data.
- WSTRB  in  WSTRB_WIDTH  byte enables.
- WLAST  in  1  last beat marker.
- WVALID  in  1  data valid.
- WREADY  out  1  data ready.
- BID  out  AWID_WIDTH  response ID.
- BRESP  out  2  00 OKAY, 10 SLVERR.
- BVALID  out  1  response valid.
- BREADY  in  1  response ready.
- dbg_addr  in  AWADDR_WIDTH-LANE_BITS  debug word index.
- dbg_rdata  out  WDATA_WIDTH  memory word at dbg_addr, 1-cycle latency.

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE; AWREADY=1 once rst_n is released, WREADY=0, BVALID=0, BID=0, BRESP=00, dbg_rdata=0.
  - Memory contents are not cleared.
  - Reset mid-burst aborts the burst: beats already written remain, no response is issued.
- FSM states: IDLE -> DATA -> RESP -> IDLE. Only one transaction is outstanding.
- IDLE:
  - AWREADY=1.
  - On AWVALID&&AWREADY, capture AWID, AWADDR, AWLEN, AWSIZE and AWBURST, clear beat_cnt and err, and go to DATA.
  - WREADY goes high the next cycle.
  - err is set at capture if AWBURST is 10 or 11, or if AWSIZE>LANE_BITS.
- DATA:
  - WREADY=1, AWREADY=0.
  - Each W handshake writes byte lane i of mem[addr[AWADDR_WIDTH-1:LANE_BITS]] when WSTRB[i]=1, unless err=1 or beat_cnt>AWLEN.
  - No size-based lane masking is applied; correct lane placement is the master's job.
  - Address update per beat: INCR adds 2^AWSIZE modulo 2^AWADDR_WIDTH (wraps from top of memory to 0); FIXED keeps the address.
  - beat_cnt is 9 bits, increments per beat and saturates at 256.
  - Beat beyond AWLEN+1 without WLAST: not written, err set.
  - WLAST handshake ends the burst and moves to RESP. If beat_cnt (including this beat) != AWLEN+1, err is set for the response.
- RESP:
  - BVALID=1, BID=captured AWID, BRESP = err ? 10 : 00.
  - BID/BRESP stay stable while BVALID=1 and BREADY=0.
  - On BREADY handshake, go to IDLE and AWREADY=1 the next cycle.
- Latency:
  - AW handshake at cycle N gives WREADY at N+1.
  - WLAST handshake at M gives BVALID at M+1.
  - Minimum single-beat transaction occupies 3 cycles.
- AWVALID asserted while not in IDLE is ignored until IDLE (AWREADY=0).
- WVALID before the AW handshake is not accepted (WREADY=0).
- Debug read is registered: dbg_rdata(t+1)=mem[dbg_addr(t)].
- A same-cycle write and debug read of the same word returns the old data.

Test Plan:
- Reset then INCR AWADDR=0x010, AWLEN=3, AWSIZE=3, AWID=5, WSTRB=FF, data 0x11..,0x22..,0x33..,0x44.. -> words 2..5 hold the data; BID=5, BRESP=00; BVALID exactly 1 cycle after the WLAST beat.
- FIXED AWADDR=0x040, AWLEN=1; beat1 WSTRB=0F data A, beat2 WSTRB=F0 data B -> word 8 = {B[63:32],A[31:0]}; BRESP=00.
- INCR AWADDR=0x3F8, AWLEN=1, AWSIZE=3 -> beat1 lands in word 127, beat2 wraps to word 0; BRESP=00.
- AWBURST=10, AWLEN=0 -> beat accepted, memory unchanged, BRESP=10. Separately AWLEN=3 with WLAST on beat 2 -> 2 beats written, BRESP=10.
- BREADY held low 5 cycles with a second AWVALID pending -> BVALID/BID stable, AWREADY=0; AW accepted 1 cycle after the B handshake.
- rst_n pulsed low after beat 2 of a 4-beat burst -> BVALID=0, AWREADY=1 after release, beats 1-2 retained, beats 3-4 absent.
